serial_add_ctrl: RTL



---
 rtl/serial_add_pkg.sv | 21 ++
 rtl/fa_cell.sv | 21 ++
 rtl/serial_add_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add/subtract sequencer.
// Holds the FSM encoding, the width ceiling and the half-adder helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 32;

  // {carry, sum} of one half-adder stage
  function automatic logic [1:0] half_add(
    input logic x,
    input logic y
  );
    return {x & y, x ^ y};
  endfunction

endpackage

// File: rtl/fa_cell.sv
// 1-bit full adder: two half-adder stages, carries merged with an OR.
// Purely combinational.
module fa_cell
  import serial_add_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic [1:0] h0;
  logic [1:0] h1;

  assign h0   = half_add(a, b);
  assign h1   = half_add(h0[0], cin);
  assign s    = h1[0];
  assign cout = h0[1] | h1[1];

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: operands stream LSB-first
// through one full-adder cell, one bit per enabled clock.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;

  logic             s;
  logic             cout;
  logic             c_msb;
  logic [WIDTH-1:0] res_nxt;

  fa_cell u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .s    (s),
    .cout (cout)
  );

  // carry into the MSB is what sits in the flop on the last bit
  assign c_msb   = carry;
  assign res_nxt = {s, res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      sh_a      <= '0;
      sh_b      <= '0;
      res       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= op_a;
            sh_b  <= sub ? ~op_b : op_b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res   <= res_nxt;
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          carry <= cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            sum       <= res_nxt;
            carry_out <= cout;
            overflow  <= c_msb ^ cout;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
